// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads the zero-latency instruction memory
// and fills the IF/ID register, stopping on a halt word or an illegal fetch address.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 4096,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    localparam logic [31:0] LAST_ADDR = 32'(MEM_DEPTH - 4);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        fetch_legal;
    logic [31:0] pc_plus4;

    // Word-aligned and inside the memory; keeps pc+4 from ever wrapping in RUN.
    assign fetch_legal = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_ADDR);
    assign pc_plus4    = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = 1'b0;
        if (state_q == ST_RUN) begin
            if (redirect) begin
                pc_d = redirect_pc;
            end else if (stall) begin
                ifid_valid_d = ifid_valid_q & ~flush;
            end else if (!fetch_legal) begin
                state_d = ST_FAULT;
            end else if (inst == HALT_WORD) begin
                state_d = ST_HALTED;
            end else begin
                // A flush only squashes the captured slot; the PC still advances.
                ifid_inst_d  = inst;
                ifid_pc_d    = pc_q;
                ifid_pc4_d   = pc_plus4;
                ifid_valid_d = ~flush;
                pc_d         = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            ifid_inst_q  <= 32'd0;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign inst_addr  = pc_q;
    assign ifid_inst  = ifid_inst_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign halted     = (state_q == ST_HALTED);
    assign fault      = (state_q == ST_FAULT);

endmodule
